// File: rtl/tetris_pkg.sv
// Shared playfield geometry and cell indexing for the single-block Tetris grid.
// The occupancy map is row-major: bit index = row*GRID_W + col, row 0 at the top.
package tetris_pkg;

   localparam int GRID_W = 16;
   localparam int GRID_H = 16;

   localparam logic [3:0] SPAWN_ROW = 4'd0;
   localparam logic [3:0] SPAWN_COL = 4'd7;

   function automatic logic [7:0] cell_idx(input logic [3:0] row, input logic [3:0] col);
      return 8'(int'(row) * GRID_W + int'(col));
   endfunction

endpackage

// File: rtl/grid_row_clear.sv
// Combinational row clear: if the row that just received a locked block is full,
// drop it and shift every row above it down by one, refilling row 0 with zeros.
module grid_row_clear
   import tetris_pkg::*;
(
   input  logic [255:0] field,
   input  logic [3:0]   lock_row,
   output logic [255:0] cleared
);

   logic row_full;

   // Only the lock row can have become full this cycle, so at most one row is removed.
   assign row_full = &field[cell_idx(lock_row, 4'd0) +: GRID_W];

   always_comb begin
      cleared = field;
      if (row_full) begin
         for (int r = 0; r < GRID_H; r++) begin
            if (r <= int'(lock_row)) begin
               if (r == 0) begin
                  cleared[0 +: GRID_W] = '0;
               end else begin
                  cleared[r*GRID_W +: GRID_W] = field[(r-1)*GRID_W +: GRID_W];
               end
            end
         end
      end
   end

endmodule

// File: rtl/single_block_grid.sv
// 16x16 playfield with one falling 1x1 block: horizontal steering, gravity,
// lock into the settled field, single-row clear, respawn and game-over wipe.
module single_block_grid
   import tetris_pkg::*;
#(
   parameter int DROP_PERIOD = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         ctrl1,
   input  logic         ctrl2,
   output logic [255:0] grid_out
);

   localparam int               CNT_W    = (DROP_PERIOD > 1) ? $clog2(DROP_PERIOD) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DROP_PERIOD - 1);

   logic [255:0]     settled, settled_nx;
   logic [255:0]     locked, compacted;
   logic [3:0]       row, row_nx;
   logic [3:0]       col, col_nx, col_mv;
   logic [CNT_W-1:0] drop_cnt, drop_cnt_nx;
   logic             tick, move_l, move_r;

   assign grid_out = settled | (256'b1 << cell_idx(row, col));

   assign move_l = ctrl1 & ~ctrl2;
   assign move_r = ctrl2 & ~ctrl1;

   // Horizontal move resolves first; gravity and lock then work from col_mv.
   always_comb begin
      col_mv = col;
      if (move_l && (col != 4'd0) && !settled[cell_idx(row, col - 4'd1)]) begin
         col_mv = col - 4'd1;
      end else if (move_r && (col != 4'(GRID_W - 1)) && !settled[cell_idx(row, col + 4'd1)]) begin
         col_mv = col + 4'd1;
      end
   end

   assign locked = settled | (256'b1 << cell_idx(row, col_mv));

   grid_row_clear u_row_clear (
      .field    (locked),
      .lock_row (row),
      .cleared  (compacted)
   );

   always_comb begin
      tick        = (drop_cnt == CNT_LAST);
      drop_cnt_nx = tick ? '0 : drop_cnt + CNT_W'(1);
      settled_nx  = settled;
      row_nx      = row;
      col_nx      = col_mv;
      if (tick) begin
         if ((row != 4'(GRID_H - 1)) && !settled[cell_idx(row + 4'd1, col_mv)]) begin
            row_nx = row + 4'd1;
         end else begin
            row_nx = SPAWN_ROW;
            col_nx = SPAWN_COL;
            // A settled spawn cell means the stack reached the top: wipe the field.
            settled_nx = compacted[cell_idx(SPAWN_ROW, SPAWN_COL)] ? '0 : compacted;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         settled  <= '0;
         row      <= SPAWN_ROW;
         col      <= SPAWN_COL;
         drop_cnt <= '0;
      end else begin
         settled  <= settled_nx;
         row      <= row_nx;
         col      <= col_nx;
         drop_cnt <= drop_cnt_nx;
      end
   end

endmodule

// File: tb/tb_single_block_grid.sv
// Directed bench for single_block_grid: one instance at DROP_PERIOD=1, one at 4,
// expected occupancy maps built from hand-derived cell positions.
module tb_single_block_grid;

   logic         clk = 1'b0;
   logic         rst1, l1, r1;
   logic         rst4, l4, r4;
   logic [255:0] g1, g4;
   logic [255:0] exp_v;
   int           total = 0;
   int           bad = 0;

   always #5 clk = ~clk;

   single_block_grid #(.DROP_PERIOD(1)) u_p1 (
      .clk      (clk),
      .reset    (rst1),
      .ctrl1    (l1),
      .ctrl2    (r1),
      .grid_out (g1)
   );

   single_block_grid #(.DROP_PERIOD(4)) u_p4 (
      .clk      (clk),
      .reset    (rst4),
      .ctrl1    (l4),
      .ctrl2    (r4),
      .grid_out (g4)
   );

   function automatic logic [255:0] cb(input int r, input int c);
      logic [255:0] one;
      one = 256'b1;
      return one << (r * 16 + c);
   endfunction

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic drop_at(input int c);
      int n;
      n = (c < 7) ? 7 - c : c - 7;
      l1 = (c < 7);
      r1 = (c > 7);
      clks(n);
      l1 = 1'b0;
      r1 = 1'b0;
      clks(16 - n);
   endtask

   initial begin
      rst1 = 1'b1; l1 = 1'b0; r1 = 1'b0;
      rst4 = 1'b1; l4 = 1'b0; r4 = 1'b0;

      // reset state and reset dominance over ctrl
      clks(1);
      chk("reset", g1, cb(0, 7));
      l1 = 1'b1;
      clks(3);
      chk("reset_hold_ctrl", g1, cb(0, 7));
      l1 = 1'b0;
      rst1 = 1'b0;

      // free fall and first lock
      clks(15);
      chk("fall_row15", g1, cb(15, 7));
      clks(1);
      chk("lock_respawn", g1, cb(15, 7) | cb(0, 7));

      // side move into a settled cell is refused, lock happens at the original column
      r1 = 1'b1;
      clks(1);
      r1 = 1'b0;
      chk("move_right_fall", g1, cb(15, 7) | cb(1, 8));
      clks(14);
      chk("beside_settled", g1, cb(15, 7) | cb(15, 8));
      l1 = 1'b1;
      clks(1);
      l1 = 1'b0;
      chk("blocked_move_lock", g1, cb(15, 7) | cb(15, 8) | cb(0, 7));

      // left wall saturation, both-pressed, single right
      rst1 = 1'b1; clks(1); rst1 = 1'b0;
      l1 = 1'b1;
      clks(7);
      chk("left_7moves", g1, cb(7, 0));
      clks(1);
      chk("left_wall_hold", g1, cb(8, 0));
      r1 = 1'b1;
      clks(1);
      chk("both_no_move", g1, cb(9, 0));
      l1 = 1'b0;
      clks(1);
      chk("right_one", g1, cb(10, 1));
      r1 = 1'b0;

      // right wall saturation
      rst1 = 1'b1; clks(1); rst1 = 1'b0;
      r1 = 1'b1;
      clks(9);
      chk("right_wall_hold", g1, cb(9, 15));
      r1 = 1'b0;

      // fill bottom row, clear on the 16th lock
      rst1 = 1'b1; clks(1); rst1 = 1'b0;
      drop_at(0);
      chk("fill_first", g1, cb(15, 0) | cb(0, 7));
      for (int c = 1; c < 15; c++) drop_at(c);
      exp_v = cb(0, 7);
      for (int c = 0; c < 15; c++) exp_v = exp_v | cb(15, c);
      chk("fill_15", g1, exp_v);
      drop_at(15);
      chk("row_clear", g1, cb(0, 7));

      // stack column 7 to the top: game over wipe
      rst1 = 1'b1; clks(1); rst1 = 1'b0;
      exp_v = '0;
      for (int k = 0; k < 15; k++) begin
         clks(16 - k);
         exp_v = exp_v | cb(15 - k, 7);
         if (k == 0) chk("stack_1", g1, exp_v | cb(0, 7));
         if (k == 1) chk("stack_2", g1, exp_v | cb(0, 7));
      end
      chk("stack_15", g1, exp_v | cb(0, 7));
      clks(1);
      chk("game_over", g1, cb(0, 7));
      clks(1);
      chk("after_game_over_fall", g1, cb(1, 7));

      // DROP_PERIOD=4 instance
      rst4 = 1'b0;
      clks(3);
      chk("p4_no_tick", g4, cb(0, 7));
      clks(1);
      chk("p4_first_tick", g4, cb(1, 7));
      r4 = 1'b1;
      clks(3);
      chk("p4_moves", g4, cb(1, 10));
      clks(1);
      chk("p4_move_and_tick", g4, cb(2, 11));
      r4 = 1'b0;
      clks(2);
      chk("p4_hold_row", g4, cb(2, 11));
      rst4 = 1'b1;
      clks(1);
      chk("p4_midfall_reset", g4, cb(0, 7));
      rst4 = 1'b0;
      clks(3);
      chk("p4_cnt_restart", g4, cb(0, 7));
      clks(1);
      chk("p4_tick_after_reset", g4, cb(1, 7));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
